// File: rtl/uart_pkg.sv
// Shared UART types and defaults for the receive and transmit sides.
package uart_pkg;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 16;
    localparam int UART_DEFAULT_DATA_BITS    = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } uart_rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } uart_tx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, LSB-first 8N1-style frames,
// valid/ready output with framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DEFAULT_DATA_BITS
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("uart_rx: DATA_BITS must be in 5..9");
    end

    logic                 rx_sync;
    logic                 rx_prev_q;
    logic                 fall;
    uart_rx_state_e       state_q;
    logic [CW-1:0]        cnt_q;
    logic [IW-1:0]        idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 fe_q;
    logic                 ov_q;

    uart_sync2 #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .d_i     (rx_i),
        .q_o     (rx_sync)
    );

    // Only a 1->0 transition arms the receiver; a held-low line does not.
    assign fall = rx_prev_q & ~rx_sync;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx_prev_q <= 1'b1;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            rx_prev_q <= rx_sync;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
            if (valid_q && ready_i) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (fall) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        if (!rx_sync) begin
                            state_q <= RX_DATA;
                            idx_q   <= '0;
                        end else begin
                            state_q <= RX_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync, shift_q[DATA_BITS-1:1]};
                        idx_q   <= idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    // Leave at mid-stop so the next start edge is never missed.
                    if (cnt_q == CNT_FULL) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (!rx_sync) begin
                            fe_q <= 1'b1;
                        end else if (!valid_q || ready_i) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ov_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = fe_q;
    assign overrun_o   = ov_q;
    assign busy_o      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: vector table plus multi-cycle corner sequences.
`timescale 1ns/100ps
module tb_uart_rx;

    localparam int  CPB    = 16;
    localparam int  DB     = 8;
    localparam real BIT_NS = 160.0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx = 1'b1;
    logic          ready = 1'b0;
    logic [DB-1:0] data;
    logic          valid;
    logic          fe;
    logic          ov;
    logic          busy;

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .rx_i       (rx),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (ready),
        .frame_err_o(fe),
        .overrun_o  (ov),
        .busy_o     (busy)
    );

    int nvec = 0;
    int nerr = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    logic [7:0] acc[$];

    always @(negedge clk) begin
        if (fe) fe_cnt++;
        if (ov) ov_cnt++;
        if (fe && ov) both_cnt++;
        if (valid && ready) acc.push_back(data);
    end

    typedef struct {
        logic [7:0] din;
        logic       stopb;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_fe;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopb,
                              input real bt);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            #(bt);
        end
        rx = stopb;
        #(bt);
    endtask

    task automatic consume();
        @(negedge clk);
        if (valid) begin
            @(posedge clk);
            #2 ready = 1'b1;
            @(posedge clk);
            #2 ready = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int f0, o0, a0, lat;

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        tbl[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
        tbl[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        tbl[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};
        tbl[5] = '{8'h5A, 1'b0, 1'b0, 8'h00, 1};
        tbl[6] = '{8'h96, 1'b1, 1'b1, 8'h96, 0};

        #12;
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_fe", fe, 0);
        chk("rst_ov", ov, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(4);

        // Latency: start edge to valid visible = 3 + CPB/2 + CPB*DB + CPB.
        f0 = fe_cnt;
        @(negedge clk);
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, BIT_NS);
            begin
                while (!valid && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        rx = 1'b1;
        cycles(4);
        chk("t1_latency", lat, 3 + CPB / 2 + CPB * DB + CPB);
        chk("t1_valid", valid, 1);
        chk("t1_data", data, 8'hA5);
        chk("t1_fe", fe_cnt - f0, 0);
        chk("t1_busy", busy, 0);

        for (int v = 0; v < 7; v++) begin
            consume();
            f0 = fe_cnt;
            o0 = ov_cnt;
            @(negedge clk);
            send_frame(tbl[v].din, tbl[v].stopb, BIT_NS);
            rx = 1'b1;
            cycles(2 * CPB);
            chk($sformatf("vec%0d_valid", v), valid, tbl[v].exp_valid);
            if (tbl[v].exp_valid) begin
                chk($sformatf("vec%0d_data", v), data, tbl[v].exp_data);
            end
            chk($sformatf("vec%0d_fe", v), fe_cnt - f0, tbl[v].exp_fe);
            chk($sformatf("vec%0d_ov", v), ov_cnt - o0, 0);
        end

        // Glitch on start bit aborts without flags.
        consume();
        f0 = fe_cnt;
        o0 = ov_cnt;
        @(negedge clk);
        rx = 1'b0;
        cycles(4);
        rx = 1'b1;
        cycles(1);
        chk("t2_busy_start", busy, 1);
        cycles(200);
        chk("t2_valid", valid, 0);
        chk("t2_fe", fe_cnt - f0, 0);
        chk("t2_ov", ov_cnt - o0, 0);
        chk("t2_busy", busy, 0);

        // Framing error then break: one pulse, no re-arm.
        f0 = fe_cnt;
        @(negedge clk);
        send_frame(8'h3C, 1'b0, BIT_NS);
        cycles(100);
        chk("t3_fe", fe_cnt - f0, 1);
        chk("t3_valid", valid, 0);
        chk("t3_busy", busy, 0);
        rx = 1'b1;
        cycles(2 * CPB);
        chk("t3_busy_after", busy, 0);

        // Overrun: second word dropped, first retained.
        consume();
        f0 = fe_cnt;
        o0 = ov_cnt;
        @(negedge clk);
        send_frame(8'h11, 1'b1, BIT_NS);
        rx = 1'b1;
        cycles(8);
        send_frame(8'h22, 1'b1, BIT_NS);
        rx = 1'b1;
        cycles(2 * CPB);
        chk("t4_valid", valid, 1);
        chk("t4_data", data, 8'h11);
        chk("t4_ov", ov_cnt - o0, 1);
        chk("t4_fe", fe_cnt - f0, 0);
        a0 = acc.size();
        @(posedge clk);
        #2 ready = 1'b1;
        @(posedge clk);
        #2 ready = 1'b0;
        @(negedge clk);
        chk("t4_valid_fall", valid, 0);
        chk("t4_acc_n", acc.size() - a0, 1);
        chk("t4_acc_data", acc[acc.size() - 1], 8'h11);

        // Back-to-back frames with bit-period skew, always ready.
        for (int s = 0; s < 2; s++) begin
            real bt;
            bt = (s == 0) ? BIT_NS * 0.97 : BIT_NS * 1.03;
            @(posedge clk);
            #2 ready = 1'b1;
            f0 = fe_cnt;
            o0 = ov_cnt;
            a0 = acc.size();
            @(negedge clk);
            send_frame(8'h00, 1'b1, bt);
            send_frame(8'hFF, 1'b1, bt);
            rx = 1'b1;
            cycles(3 * CPB);
            chk($sformatf("t5_%0d_n", s), acc.size() - a0, 2);
            if (acc.size() - a0 == 2) begin
                chk($sformatf("t5_%0d_w0", s), acc[a0], 8'h00);
                chk($sformatf("t5_%0d_w1", s), acc[a0 + 1], 8'hFF);
            end
            chk($sformatf("t5_%0d_fe", s), fe_cnt - f0, 0);
            chk($sformatf("t5_%0d_ov", s), ov_cnt - o0, 0);
        end

        // Asynchronous reset mid-DATA, then normal reception.
        @(posedge clk);
        #2 ready = 1'b0;
        @(negedge clk);
        send_frame(8'h77, 1'b1, BIT_NS);
        rx = 1'b1;
        cycles(2 * CPB);
        chk("t6_pre_valid", valid, 1);
        @(negedge clk);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rx = a0[0] ^ a0[0] ^ ((8'h5A >> i) & 1);
            #(BIT_NS);
        end
        chk("t6_busy_pre", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", valid, 0);
        chk("t6_rst_data", data, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_fe", fe, 0);
        chk("t6_rst_ov", ov, 0);
        rx = 1'b1;
        cycles(3);
        reset_n = 1'b1;
        cycles(5);
        send_frame(8'h5A, 1'b1, BIT_NS);
        rx = 1'b1;
        cycles(2 * CPB);
        chk("t6_valid", valid, 1);
        chk("t6_data", data, 8'h5A);

        chk("never_both", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART serial receiver, the receive-side counterpart of the team's UART transmit controller and datapath.
- Synchronises the asynchronous rx line and detects the start bit.
- Samples each bit at mid-bit using an internal baud counter; frame is LSB-first, 1 start bit, DATA_BITS data bits, 1 stop bit, no parity.
- Presents each received byte on a valid/ready interface toward the core, with framing-error and overrun flags.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; must be >= 4 (elaboration assertion).
DATA_BITS, 8, data bits per frame; legal range 5..9.

Ports:
clk_i  input  1  system clock; one clock domain only.
reset_ni  input  1  reset; asynchronous and active-low.
rx_i  input  1  serial line, asynchronous to clk_i, idles high.
data_o  output  DATA_BITS  last received word.
valid_o  output  1  data_o holds an unconsumed word.
ready_i  input  1  consumer accepts data_o this cycle when valid_o=1.
frame_err_o  output  1  one-cycle pulse: stop bit sampled 0.
overrun_o  output  1  one-cycle pulse: new word dropped because valid_o=1 and ready_i=0.
busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset_ni=0, asynchronous): FSM to IDLE; both synchroniser flops and the edge-detect flop set to 1.
- Reset values of outputs: data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0. Baud counter and bit index cleared.
- Reset mid-frame discards the partial word. The next frame after release is received normally.
- Input path: two-flop synchroniser on rx_i, then one edge-detect flop.
- Start condition is a falling edge only: previous synced value 1, current 0. A line held low (break) never re-arms the receiver.
- Baud counter width is $clog2(CLKS_PER_BIT). It is cleared on every state entry.
- FSM states:
  - IDLE: on a falling edge, go to START.
  - START: wait until count = CLKS_PER_BIT/2-1 (integer division). If synced rx=0 at that point, go to DATA with bit_idx=0. If rx=1, treat it as a glitch and return to IDLE with no flags.
  - DATA: wait until count = CLKS_PER_BIT-1, then sample into the shift register. Shift right, new bit enters at the MSB, so the first received bit ends in bit 0. Increment bit_idx. After sample number DATA_BITS, go to STOP.
  - STOP: wait until count = CLKS_PER_BIT-1, sample, then go to IDLE on the next cycle.
    - Sample 1: word completes.
    - Sample 0: frame_err_o pulses for exactly 1 cycle; the word is discarded and valid_o/data_o are unchanged.
- Returning to IDLE at the stop-bit midpoint gives half a bit of slack, so back-to-back frames are caught.
- Latency: valid_o and data_o update on the clock edge after the stop-bit sample. The detected falling edge lags rx_i by 3 clk_i cycles (synchroniser plus edge detect).
- Output handshake:
  - valid_o stays high and data_o stays stable until a cycle with valid_o=1 and ready_i=1. valid_o falls on the next edge unless a new word completes in that same cycle.
  - Word completes and (valid_o=0 or ready_i=1): load data_o, valid_o=1, no overrun. This covers the simultaneous consume-and-complete case.
  - Word completes while valid_o=1 and ready_i=0: keep the old data_o, drop the new word, pulse overrun_o for 1 cycle.
- frame_err_o and overrun_o are never asserted together; each occurs at most once per frame.

Decomposition:
Shared package uart_pkg:
- typedef enum logic [1:0] uart_rx_state_e {RX_IDLE, RX_START, RX_DATA, RX_STOP};
- localparam UART_DEFAULT_CLKS_PER_BIT = 16;
- localparam UART_DEFAULT_DATA_BITS = 8.
The transmit controller's state constants should migrate into the same package.

One sub-module, uart_sync2: two-flop synchroniser with parameterised reset value (1 here). It is reusable for other asynchronous inputs.

Test Plan:
All scenarios use CLKS_PER_BIT=16 and DATA_BITS=8.
1. Drive frame 0xA5 on rx_i with ready_i=0 -> valid_o=1 and data_o=0xA5 on the edge after the stop sample; frame_err_o=0; busy_o=0 afterwards.
2. Pulse rx_i low for 4 cycles, then hold high -> START aborts to IDLE; valid_o, frame_err_o and overrun_o stay 0 for 200 cycles.
3. Frame 0x3C with stop bit driven 0 -> frame_err_o high for exactly 1 cycle; valid_o stays 0. Holding rx_i low for 100 more cycles gives no new START.
4. Frames 0x11 then 0x22 with ready_i=0 -> data_o=0x11 retained and overrun_o pulses once at the second stop sample. Then ready_i=1 for 1 cycle -> valid_o falls the next cycle.
5. Frames 0x00 and 0xFF back-to-back with no idle gap and ready_i=1, plus ±3% bit-period skew -> both words delivered in order with no flags.
6. Assert reset_ni=0 mid-DATA after 4 bits -> all outputs 0 asynchronously. After release, frame 0x5A -> data_o=0x5A, valid_o=1.
